// File: rtl/hls_fp17_add_pkg.sv
// Shared constants and channel state encoding for the fp17 adder channel wrappers
// (chn_a / chn_b input channels and the chn_o output transmitter).
package hls_fp17_add_pkg;

  localparam int FP17_W         = 17;
  localparam int CHN_SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    CHN_EMPTY = 2'd0,
    CHN_HALF  = 2'd1,
    CHN_FULL  = 2'd2
  } chn_state_e;

endpackage

// File: rtl/hls_fp17_add_core_chn_o_rsci_tx_if.sv
// chn_o channel bundle: core-side write handshake plus downstream z/lz/vz wires.
// master = the transmitter, slave = the core/downstream environment.
interface hls_fp17_add_core_chn_o_rsci_tx_if
  import hls_fp17_add_pkg::*;
#(
  parameter int WIDTH = FP17_W
);

  logic             iswt0;
  logic [WIDTH-1:0] d;
  logic             wen_comp;
  logic             bawt;
  logic [WIDTH-1:0] z;
  logic             lz;
  logic             vz;

  modport master (
    input  iswt0, d, vz,
    output wen_comp, bawt, z, lz
  );

  modport slave (
    output iswt0, d, vz,
    input  wen_comp, bawt, z, lz
  );

endinterface

// File: rtl/hls_fp17_add_chn_o_skid_mem.sv
// Skid-buffer storage for chn_o: DEPTH x WIDTH registers, wrapping write/read
// pointers and an asynchronous read of the head entry.
module hls_fp17_add_chn_o_skid_mem
  import hls_fp17_add_pkg::*;
#(
  parameter int WIDTH = FP17_W,
  parameter int DEPTH = CHN_SKID_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  localparam int PTR_W = (DEPTH > 2) ? 2 : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Non-power-of-two depths must wrap explicitly rather than by overflow.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/hls_fp17_add_core_chn_o_rsci_tx.sv
// chn_o output transmitter: skid-buffered z/lz/vz wire-wait sender for the fp17 adder core.
// Optional stall counter port enabled by defining FP17_CHN_O_STALL_CNT_EN.
module hls_fp17_add_core_chn_o_rsci_tx
  import hls_fp17_add_pkg::*;
#(
  parameter int WIDTH = FP17_W,
  parameter int DEPTH = CHN_SKID_DEPTH
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rst,
  input  logic        core_wen,
  hls_fp17_add_core_chn_o_rsci_tx_if.master chn_o
`ifdef FP17_CHN_O_STALL_CNT_EN
  ,
  output logic [15:0] chn_o_stall_cnt
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [1:0] ST_EMPTY = CHN_EMPTY;
  localparam logic [1:0] ST_HALF  = CHN_HALF;
  localparam logic [1:0] ST_FULL  = CHN_FULL;

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             push;
  logic             pop;

  // Handshake flags come from registered state only, so vz never reaches wen_comp.
  assign chn_o.wen_comp = (state != ST_FULL);
  assign chn_o.lz       = (state != ST_EMPTY);
  assign push           = chn_o.iswt0 & core_wen & chn_o.wen_comp & ~nvdla_core_rst;
  assign pop            = chn_o.lz & chn_o.vz;
  assign chn_o.bawt     = push;

  always_comb begin
    count_nxt = count;
    state_nxt = state;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
    if (count_nxt == CNT_W'(0)) begin
      state_nxt = ST_EMPTY;
    end else if (count_nxt == CNT_W'(DEPTH)) begin
      state_nxt = ST_FULL;
    end else begin
      state_nxt = ST_HALF;
    end
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      count <= '0;
      state <= ST_EMPTY;
    end else begin
      count <= count_nxt;
      state <= state_nxt;
    end
  end

  hls_fp17_add_chn_o_skid_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_skid_mem (
    .clk   (nvdla_core_clk),
    .rst   (nvdla_core_rst),
    .push  (push),
    .pop   (pop),
    .wdata (chn_o.d),
    .rdata (chn_o.z)
  );

`ifdef FP17_CHN_O_STALL_CNT_EN
  // Counts cycles a valid word waits on downstream; saturates rather than wrapping.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      chn_o_stall_cnt <= 16'h0000;
    end else if (chn_o.lz && !chn_o.vz && (chn_o_stall_cnt != 16'hFFFF)) begin
      chn_o_stall_cnt <= chn_o_stall_cnt + 16'h0001;
    end else begin
      chn_o_stall_cnt <= chn_o_stall_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_hls_fp17_add_core_chn_o_rsci_tx.sv
// Testbench for hls_fp17_add_core_chn_o_rsci_tx: queue-based channel model checked every
// cycle, plus directed vectors with literal expectations.
module tb_hls_fp17_add_core_chn_o_rsci_tx;

  localparam int W = 17;
  localparam int D = 2;

  logic clk = 1'b0;
  logic rst;
  logic core_wen;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] model[$];
  logic [W-1:0] popped[$];
  logic [15:0]  stall_m = 16'h0000;

  hls_fp17_add_core_chn_o_rsci_tx_if #(.WIDTH(W)) bus ();

`ifdef FP17_CHN_O_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  hls_fp17_add_core_chn_o_rsci_tx #(.WIDTH(W), .DEPTH(D)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rst  (rst),
    .core_wen        (core_wen),
    .chn_o           (bus)
`ifdef FP17_CHN_O_STALL_CNT_EN
    ,
    .chn_o_stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Channel model: a FIFO of at most D words; outputs checked mid-cycle, then the
  // transfers that the next rising edge will commit are applied.
  always @(negedge clk) begin : compare
    bit push_m;
    bit pop_m;
    if (rst) begin
      model.delete();
      stall_m = 16'h0000;
      check("rst_lz",   {31'd0, bus.lz},       32'd0);
      check("rst_wen",  {31'd0, bus.wen_comp}, 32'd1);
      check("rst_bawt", {31'd0, bus.bawt},     32'd0);
      check("rst_z",    {15'd0, bus.z},        32'd0);
`ifdef FP17_CHN_O_STALL_CNT_EN
      check("rst_stall", {16'd0, stall_cnt}, 32'd0);
`endif
    end else begin
      push_m = bus.iswt0 && core_wen && (model.size() < D);
      pop_m  = (model.size() != 0) && bus.vz;
      check("m_lz",   {31'd0, bus.lz},       {31'd0, model.size() != 0});
      check("m_wen",  {31'd0, bus.wen_comp}, {31'd0, model.size() != D});
      check("m_bawt", {31'd0, bus.bawt},     {31'd0, push_m});
      if (model.size() != 0) check("m_z", {15'd0, bus.z}, {15'd0, model[0]});
`ifdef FP17_CHN_O_STALL_CNT_EN
      check("m_stall", {16'd0, stall_cnt}, {16'd0, stall_m});
      if (model.size() != 0 && !bus.vz && stall_m != 16'hFFFF) stall_m = stall_m + 16'd1;
`endif
      if (bus.lz && bus.vz) popped.push_back(bus.z);
      if (pop_m) void'(model.pop_front());
      if (push_m) model.push_back(bus.d);
    end
  end

  // Holds iswt0/d until the write is accepted; returns just after that rising edge.
  task automatic push_word(input logic [W-1:0] w);
    bit ok;
    ok = 1'b0;
    bus.iswt0 = 1'b1;
    bus.d     = w;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      ok = bus.bawt;
      @(posedge clk);
      #1;
    end
    check("push_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst       = 1'b1;
    core_wen  = 1'b1;
    bus.iswt0 = 1'b1;
    bus.d     = 17'h1ABCD;
    bus.vz    = 1'b0;

    // 1: reset hold with iswt0 asserted, then the first push
    cycles(3);
    rst = 1'b0;
    @(negedge clk);
    check("t1_bawt", {31'd0, bus.bawt}, 32'd1);
    cycles(1);
    bus.iswt0 = 1'b0;
    @(negedge clk);
    check("t1_lz", {31'd0, bus.lz}, 32'd1);
    check("t1_z",  {15'd0, bus.z},  32'h1ABCD);
    cycles(1);
    bus.vz = 1'b1;
    cycles(3);

    // 2: streaming 100 words with vz held high
    popped.delete();
    for (int i = 1; i <= 100; i++) push_word(17'(i));
    bus.iswt0 = 1'b0;
    cycles(4);
    check("t2_count", popped.size(), 32'd100);
    for (int i = 0; i < 100 && i < popped.size(); i++)
      check("t2_order", {15'd0, popped[i]}, i + 1);

    // 3/4: backpressure to FULL, pop with rejected push, then accepted push
    bus.vz = 1'b0;
    popped.delete();
    push_word(17'h00011);
    push_word(17'h00022);
    bus.iswt0 = 1'b1;
    bus.d     = 17'h00033;
    @(negedge clk);
    check("t3_wen_full",  {31'd0, bus.wen_comp}, 32'd0);
    check("t3_bawt_full", {31'd0, bus.bawt},     32'd0);
    check("t3_head",      {15'd0, bus.z},        32'h00011);
    cycles(2);
    bus.vz = 1'b1;
    @(negedge clk);
    check("t4_bawt_pop", {31'd0, bus.bawt}, 32'd0);
    check("t4_z_pop",    {15'd0, bus.z},    32'h00011);
    cycles(1);
    @(negedge clk);
    check("t4_bawt_next", {31'd0, bus.bawt}, 32'd1);
    check("t4_z_next",    {15'd0, bus.z},    32'h00022);
    cycles(1);
    bus.iswt0 = 1'b0;
    cycles(4);
    check("t3_count", popped.size(), 32'd3);
    if (popped.size() == 3) begin
      check("t3_w0", {15'd0, popped[0]}, 32'h00011);
      check("t3_w1", {15'd0, popped[1]}, 32'h00022);
      check("t3_w2", {15'd0, popped[2]}, 32'h00033);
    end

    // core_wen low: pushes blocked, downstream still drains
    bus.vz = 1'b0;
    core_wen  = 1'b0;
    bus.iswt0 = 1'b1;
    bus.d     = 17'h00055;
    @(negedge clk);
    check("cw_block", {31'd0, bus.bawt}, 32'd0);
    cycles(1);
    core_wen = 1'b1;
    push_word(17'h00055);
    core_wen = 1'b0;
    bus.d    = 17'h00066;
    bus.vz   = 1'b1;
    @(negedge clk);
    check("cw_bawt",  {31'd0, bus.bawt}, 32'd0);
    check("cw_drain", {15'd0, bus.z},    32'h00055);
    cycles(1);
    @(negedge clk);
    check("cw_empty", {31'd0, bus.lz}, 32'd0);
    cycles(1);
    bus.iswt0 = 1'b0;
    core_wen  = 1'b1;

    // 5: asynchronous reset while FULL
    bus.vz = 1'b0;
    push_word(17'h000A1);
    push_word(17'h000A2);
    bus.iswt0 = 1'b0;
    check("t5_full", {31'd0, bus.wen_comp}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("t5_lz_async",  {31'd0, bus.lz},       32'd0);
    check("t5_wen_async", {31'd0, bus.wen_comp}, 32'd1);
    cycles(2);
    rst = 1'b0;
    bus.vz = 1'b1;
    popped.delete();
    cycles(5);
    check("t5_no_stale", popped.size(), 32'd0);

`ifdef FP17_CHN_O_STALL_CNT_EN
    // 6: stall counter saturation
    bus.vz = 1'b0;
    push_word(17'h00077);
    bus.iswt0 = 1'b0;
    cycles(70000);
    @(negedge clk);
    check("t6_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
    cycles(1);
    bus.vz = 1'b1;
    cycles(3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
